spi_master_frame: RTL and testbench

SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) that drives SS, SCK and MOSI and samples MISO. It runs frames of 1..2^LEN_WIDTH-1 bytes, full duplex. It is the host-side counterpart of the robot's SPI slave interface: it sends command bytes (way select, stop, begin) and reads back the telemetry bytes (pose, RPM, distance, behaviour, IMU). It is used on the host FPGA and as the active end of the slave's bench.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_master_clkgen.sv | 41 ++++
 rtl/spi_master_frame.sv | 215 +++++++++++++++++++++
 tb/tb_spi_master_frame.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, frame FSM encoding and the command
// byte codes agreed between the host-side master and the robot's slave.
package spi_pkg;

  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_MSB_FIRST = 1'b1;

  localparam int SPI_BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4,
    ST_TRAIL = 3'd5,
    ST_DONE  = 3'd6
  } masterState_t;

  // Command opcodes; the way-select opcode carries the way index in its low nibble.
  localparam logic [SPI_BYTE_WIDTH-1:0] CMD_WAY_SELECT     = 8'h10;
  localparam logic [SPI_BYTE_WIDTH-1:0] CMD_STOP           = 8'h20;
  localparam logic [SPI_BYTE_WIDTH-1:0] CMD_BEGIN          = 8'h30;
  localparam logic [SPI_BYTE_WIDTH-1:0] CMD_TELEMETRY_READ = 8'h40;

endpackage

// File: rtl/spi_master_clkgen.sv
// Phase timing for the SPI master: a divider counter that ticks on the last
// cycle of every SCK half-period, plus the registered SCK line.
module spi_master_clkgen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic sckVal,
  output logic tick,
  output logic sck
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
      // SCK only moves at phase boundaries, to the level of the coming phase.
      if (clr) begin
        sck <= 1'b0;
      end else if (tick) begin
        sck <= sckVal;
      end
    end
  end

endmodule

// File: rtl/spi_master_frame.sv
// SPI mode-0 frame master: runs 1..2^LEN_WIDTH-1 byte full-duplex frames,
// requesting transmit bytes with TXACK and reporting received bytes with RXVALID.
module spi_master_frame
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int LEN_WIDTH  = 6,
  parameter int BYTE_WIDTH = SPI_BYTE_WIDTH
) (
  input  logic                  SPI_MASTER_CLOCK_50,
  input  logic                  SPI_MASTER_RESET_InLow,
  input  logic                  SPI_MASTER_START_InHigh,
  input  logic [LEN_WIDTH-1:0]  SPI_MASTER_LENGTH_InBus,
  input  logic [BYTE_WIDTH-1:0] SPI_MASTER_TXDATA_InBus,
  output logic                  SPI_MASTER_TXACK_OutHigh,
  output logic [BYTE_WIDTH-1:0] SPI_MASTER_RXDATA_OutBus,
  output logic                  SPI_MASTER_RXVALID_OutHigh,
  output logic                  SPI_MASTER_BUSY_OutHigh,
  output logic                  SPI_MASTER_DONE_OutHigh,
  output logic                  SPI_MASTER_SS_OutLow,
  output logic                  SPI_MASTER_SCK_Out,
  output logic                  SPI_MASTER_MOSI_Out,
  input  logic                  SPI_MASTER_MISO_In
);

  localparam int BIT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_WIDTH - 1);

  logic clk;
  logic rst_n;
  assign clk   = SPI_MASTER_CLOCK_50;
  assign rst_n = SPI_MASTER_RESET_InLow;

  masterState_t state;
  masterState_t stateNext;

  logic tick;
  logic sck;
  logic divEn;
  logic sckVal;

  logic accept;
  logic sampleBit;
  logic bitStep;
  logic loadNext;
  logic finish;
  logic lastBit;
  logic lastByte;

  logic [LEN_WIDTH-1:0]  lenLatch;
  logic [LEN_WIDTH-1:0]  byteCnt;
  logic [BIT_W-1:0]      bitCnt;
  logic [BYTE_WIDTH-1:0] txShift;
  logic [BYTE_WIDTH-1:0] rxShift;
  logic [BYTE_WIDTH-1:0] rxData;
  logic                  rxPend;
  logic                  rxValid;
  logic                  txAck;
  logic                  busy;
  logic                  done;
  logic                  ss;
  logic                  mosi;

  assign lastBit  = (bitCnt == LAST_BIT);
  // Compared against the latched length only; LENGTH may change mid-frame.
  assign lastByte = (byteCnt == lenLatch - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    sampleBit = 1'b0;
    bitStep   = 1'b0;
    loadNext  = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SPI_MASTER_START_InHigh && (SPI_MASTER_LENGTH_InBus != '0)) begin
          accept    = 1'b1;
          stateNext = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (tick) stateNext = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) begin
          sampleBit = 1'b1;
          stateNext = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tick) begin
          bitStep = 1'b1;
          if (!lastBit) begin
            stateNext = ST_HIGH;
          end else if (lastByte) begin
            stateNext = ST_TRAIL;
          end else begin
            loadNext  = 1'b1;
            stateNext = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) stateNext = ST_HIGH;
      end
      ST_TRAIL: begin
        if (tick) begin
          finish    = 1'b1;
          stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  assign divEn  = (state == ST_LEAD) || (state == ST_HIGH) || (state == ST_LOW) ||
                  (state == ST_GAP)  || (state == ST_TRAIL);
  assign sckVal = (stateNext == ST_HIGH);

  spi_master_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (divEn),
    .clr   (accept),
    .sckVal(sckVal),
    .tick  (tick),
    .sck   (sck)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lenLatch <= '0;
      byteCnt  <= '0;
      bitCnt   <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      rxData   <= '0;
      rxPend   <= 1'b0;
      rxValid  <= 1'b0;
      txAck    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      txAck   <= accept | loadNext;
      // Received byte is published one cycle after its last bit is sampled.
      rxPend  <= sampleBit && lastBit;
      rxValid <= rxPend;
      if (rxPend) rxData <= rxShift;

      if (accept) begin
        lenLatch <= SPI_MASTER_LENGTH_InBus;
        byteCnt  <= '0;
        bitCnt   <= '0;
        txShift  <= SPI_MASTER_TXDATA_InBus;
        mosi     <= SPI_MASTER_TXDATA_InBus[BYTE_WIDTH-1];
        ss       <= 1'b0;
        busy     <= 1'b1;
      end

      if (loadNext) begin
        txShift <= SPI_MASTER_TXDATA_InBus;
        mosi    <= SPI_MASTER_TXDATA_InBus[BYTE_WIDTH-1];
        byteCnt <= byteCnt + LEN_WIDTH'(1);
      end

      // End of HIGH: capture MISO, and on the falling edge present the next bit.
      if (sampleBit) begin
        rxShift <= {rxShift[BYTE_WIDTH-2:0], SPI_MASTER_MISO_In};
        if (!lastBit) begin
          mosi    <= txShift[BYTE_WIDTH-2];
          txShift <= txShift << 1;
        end
      end

      if (bitStep) begin
        bitCnt <= lastBit ? '0 : bitCnt + BIT_W'(1);
      end

      if (finish) begin
        ss   <= 1'b1;
        mosi <= 1'b0;
      end
      done <= finish;
      if (state == ST_DONE) busy <= 1'b0;
    end
  end

  assign SPI_MASTER_TXACK_OutHigh   = txAck;
  assign SPI_MASTER_RXDATA_OutBus   = rxData;
  assign SPI_MASTER_RXVALID_OutHigh = rxValid;
  assign SPI_MASTER_BUSY_OutHigh    = busy;
  assign SPI_MASTER_DONE_OutHigh    = done;
  assign SPI_MASTER_SS_OutLow       = ss;
  assign SPI_MASTER_SCK_Out         = sck;
  assign SPI_MASTER_MOSI_Out        = mosi;

endmodule

// File: tb/tb_spi_master_frame.sv
// Bench for spi_master_frame at CLK_DIV=4: directed frames against loopback and
// slave-reply MISO models, with a received-byte scoreboard.
module tb_spi_master_frame;

  localparam int CLK_DIV = 4;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [5:0] length;
  logic [7:0] txData;
  logic       txAck;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       done;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];
  logic [7:0] txBuf[0:7];
  logic [7:0] replyBytes[0:7];
  int         ackIdx = 0;
  int         misoMode = 0;

  int rxCnt = 0, txAckCnt = 0, doneCnt = 0, ssLowCnt = 0;
  int riseCnt = 0, edgeCnt = 0, frameRise = 0, fallCnt = 0, lowRun = 0, hiCyc = 0;
  logic        prevSck = 1'b0;
  logic [63:0] mosiBits = '0;
  int          lowRuns[$];

  spi_master_frame #(
    .CLK_DIV(CLK_DIV),
    .LEN_WIDTH(6),
    .BYTE_WIDTH(8)
  ) dut (
    .SPI_MASTER_CLOCK_50       (clk),
    .SPI_MASTER_RESET_InLow    (rstN),
    .SPI_MASTER_START_InHigh   (start),
    .SPI_MASTER_LENGTH_InBus   (length),
    .SPI_MASTER_TXDATA_InBus   (txData),
    .SPI_MASTER_TXACK_OutHigh  (txAck),
    .SPI_MASTER_RXDATA_OutBus  (rxData),
    .SPI_MASTER_RXVALID_OutHigh(rxValid),
    .SPI_MASTER_BUSY_OutHigh   (busy),
    .SPI_MASTER_DONE_OutHigh   (done),
    .SPI_MASTER_SS_OutLow      (ss),
    .SPI_MASTER_SCK_Out        (sck),
    .SPI_MASTER_MOSI_Out       (mosi),
    .SPI_MASTER_MISO_In        (miso)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  assign txData = (ackIdx < 8) ? txBuf[ackIdx] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic replyBit(input int idx);
    if (idx >= 64) return 1'b0;
    return replyBytes[idx / 8][7 - (idx % 8)];
  endfunction

  // Monitor: scoreboard pops, event counters and the MISO slave models.
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge clk);
      if (rxValid) begin
        rxCnt++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected actual=0x%0h required=no_byte", rxData);
        end else begin
          check("rx_data", {24'd0, rxData}, {24'd0, expQ.pop_front()});
        end
      end
      if (txAck) txAckCnt++;
      if (done)  doneCnt++;
      if (ss) begin
        frameRise = 0;
        fallCnt   = 0;
        lowRun    = 0;
        hiCyc     = 0;
        if (!txAck) ackIdx = 0;
      end else begin
        ssLowCnt++;
        if (txAck) ackIdx++;
        if (sck && !prevSck) begin
          riseCnt++;
          frameRise++;
          edgeCnt++;
          mosiBits = {mosiBits[62:0], mosi};
          lowRuns.push_back(lowRun);
          lowRun = 0;
        end
        if (!sck && prevSck) begin
          fallCnt++;
          edgeCnt++;
        end
        if (!sck) lowRun++;
        hiCyc = sck ? (prevSck ? hiCyc + 1 : 0) : 0;
      end
      prevSck = sck;
      case (misoMode)
        0: miso = mosi;
        1: miso = replyBit(fallCnt);
        default: miso = (sck && hiCyc == CLK_DIV - 1) ? replyBit(fallCnt) : ~replyBit(fallCnt);
      endcase
    end
  end

  task automatic startFrame(input logic [5:0] len);
    @(negedge clk);
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s actual=no_done required=done_within_%0d", name, budget);
    end
  endtask

  initial begin
    int b_rx, b_ack, b_done, b_ss, b_rise, b_edge, b_run, bad;
    rstN   = 1'b0;
    start  = 1'b0;
    length = '0;
    for (int i = 0; i < 8; i++) begin
      txBuf[i]      = 8'h00;
      replyBytes[i] = 8'h00;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done_ack_valid", {done, txAck, rxValid}, 0);
    check("rst_rxdata", rxData, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, one byte.
    misoMode = 0;
    txBuf[0] = 8'hA5;
    expQ.push_back(8'hA5);
    b_rx = rxCnt; b_ack = txAckCnt; b_done = doneCnt; b_ss = ssLowCnt;
    startFrame(6'd1);
    check("t1_first_cycle", {ss, busy, mosi, txAck}, 4'b0111);
    waitDone(200, "t1_done");
    check("t1_busy_in_done", busy, 1);
    @(negedge clk);
    check("t1_after_done", {busy, ss, mosi, sck}, 4'b0100);
    check("t1_rxvalid_count", rxCnt - b_rx, 1);
    check("t1_txack_count", txAckCnt - b_ack, 1);
    check("t1_done_count", doneCnt - b_done, 1);
    check("t1_ss_low_cycles", ssLowCnt - b_ss, 72);

    // Slave replies 3C C3 5A while the master sends 81 42 24.
    misoMode = 1;
    replyBytes[0] = 8'h3C; replyBytes[1] = 8'hC3; replyBytes[2] = 8'h5A;
    txBuf[0] = 8'h81; txBuf[1] = 8'h42; txBuf[2] = 8'h24;
    expQ.push_back(8'h3C); expQ.push_back(8'hC3); expQ.push_back(8'h5A);
    b_rx = rxCnt; b_ack = txAckCnt; b_done = doneCnt; b_ss = ssLowCnt;
    b_rise = riseCnt; b_edge = edgeCnt; b_run = lowRuns.size();
    startFrame(6'd3);
    waitDone(600, "t2_done");
    check("t2_mosi_stream", mosiBits[23:0], 24'h814224);
    check("t2_sck_rises", riseCnt - b_rise, 24);
    check("t2_sck_edges", edgeCnt - b_edge, 48);
    check("t2_lead_low", lowRuns[b_run], CLK_DIV);
    check("t2_intra_low", lowRuns[b_run + 1], CLK_DIV);
    check("t2_gap1_low", lowRuns[b_run + 8], 2 * CLK_DIV);
    check("t2_gap2_low", lowRuns[b_run + 16], 2 * CLK_DIV);
    check("t2_rxvalid_count", rxCnt - b_rx, 3);
    check("t2_txack_count", txAckCnt - b_ack, 3);
    check("t2_done_count", doneCnt - b_done, 1);
    check("t2_ss_low_cycles", ssLowCnt - b_ss, 208);
    repeat (3) @(negedge clk);

    // START with LENGTH=0 is ignored.
    b_ack = txAckCnt;
    bad = 0;
    @(negedge clk);
    start  = 1'b1;
    length = 6'd0;
    repeat (100) begin
      @(negedge clk);
      if (ss !== 1'b1 || busy !== 1'b0 || sck !== 1'b0) bad++;
    end
    start = 1'b0;
    check("t3_len0_idle_violations", bad, 0);
    check("t3_len0_txack", txAckCnt - b_ack, 0);

    // Mid-frame START ignored; back-to-back START accepted after DONE.
    misoMode = 0;
    txBuf[0] = 8'h11; txBuf[1] = 8'h22;
    expQ.push_back(8'h11); expQ.push_back(8'h22);
    b_ack = txAckCnt; b_done = doneCnt; b_ss = ssLowCnt;
    startFrame(6'd2);
    repeat (40) @(negedge clk);
    start  = 1'b1;
    length = 6'd5;
    @(negedge clk);
    start  = 1'b0;
    waitDone(400, "t4_done");
    check("t4_txack_count", txAckCnt - b_ack, 2);
    check("t4_done_count", doneCnt - b_done, 1);
    check("t4_ss_low_cycles", ssLowCnt - b_ss, 140);
    txBuf[0] = 8'hE7;
    expQ.push_back(8'hE7);
    start  = 1'b1;
    length = 6'd1;
    @(negedge clk);
    check("t4_idle_after_done", {busy, ss}, 2'b01);
    @(negedge clk);
    start = 1'b0;
    check("t4_accept_after_done", {busy, ss}, 2'b10);
    waitDone(200, "t4_b2b_done");
    repeat (3) @(negedge clk);

    // Reset during byte 2 bit 4.
    txBuf[0] = 8'h96; txBuf[1] = 8'h69; txBuf[2] = 8'h0F;
    expQ.push_back(8'h96);
    startFrame(6'd3);
    bad = 1;
    for (int n = 0; n < 600 && bad != 0; n++) begin
      @(negedge clk);
      if (frameRise >= 13) bad = 0;
    end
    check("t5_reached_byte2_bit4", bad, 0);
    check("t5_busy_before_reset", busy, 1);
    b_rx = rxCnt; b_done = doneCnt;
    #1 rstN = 1'b0;
    #1;
    check("t5_reset_outputs", {ss, sck, mosi, busy}, 4'b1000);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    b_ss = ssLowCnt;
    repeat (200) @(negedge clk);
    check("t5_no_done", doneCnt - b_done, 0);
    check("t5_no_rxvalid", rxCnt - b_rx, 0);
    check("t5_ss_stays_high", ssLowCnt - b_ss, 0);
    txBuf[0] = 8'h5A;
    expQ.push_back(8'h5A);
    b_done = doneCnt;
    startFrame(6'd1);
    waitDone(200, "t5_fresh_done");
    check("t5_fresh_done_count", doneCnt - b_done, 1);
    repeat (3) @(negedge clk);

    // MISO correct only on the last HIGH cycle of each bit.
    misoMode = 2;
    replyBytes[0] = 8'hB4; replyBytes[1] = 8'h69;
    txBuf[0] = 8'h00; txBuf[1] = 8'h00;
    expQ.push_back(8'hB4); expQ.push_back(8'h69);
    b_rx = rxCnt;
    startFrame(6'd2);
    waitDone(400, "t6_done");
    check("t6_rxvalid_count", rxCnt - b_rx, 2);
    repeat (5) @(negedge clk);

    check("rx_queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
